// File: rtl/wb_stim_pkg.sv
// Shared definitions for the Wishbone stimulus sequencer.
//   WB_DW / WB_SW   : bus data width and byte-select width
//   DEF_DATA_BASE   : default first address treated as load data
//   DEF_NOP_WORD    : default filler instruction for an empty instruction queue
//   state_e         : responder FSM states
package wb_stim_pkg;

  localparam int unsigned WB_DW = 128;
  localparam int unsigned WB_SW = WB_DW / 8;

  localparam logic [31:0] DEF_DATA_BASE = 32'h0000_1000;
  localparam logic [31:0] DEF_NOP_WORD  = 32'hF080_1003;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    RESP,
    WAITD
  } state_e;

endpackage

// File: rtl/stim_fifo.sv
// Simple synchronous FIFO used for the instruction and data stimulus queues.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, din  : write one entry; dropped when full unless popped the same cycle
//   pop, dout  : dout is the current head (combinational); pop advances it
//   full/empty : occupancy flags
//   count      : occupancy, log2(DEPTH)+1 bits
//   ovf        : single-cycle indication that a push was dropped
module stim_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is still taken when a pop frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_stim_sequencer.sv
// Wishbone slave that stands in for system memory on the a25_core bus port.
// Reads below DATA_BASE are served from the instruction queue (NOP filler when
// empty); reads at/above DATA_BASE come from the data queue, waiting up to
// TIMEOUT cycles before an error. Writes are reported as a store pulse.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_inst_push/i_inst_line : instruction queue fill (128-bit lines)
//   i_data_push/i_data_word : data queue fill (32-bit words)
//   o_iq_full/o_dq_full     : queue full flags
//   o_ovf                   : sticky, a push was dropped on a full queue
//   i_wb_*                  : core request (cyc/stb/we/adr/sel/wdat)
//   o_wb_rdat/ack/err       : registered response, rdat zero outside ack
//   o_st_valid/adr/dat/sel  : store capture pulse and held fields
module wb_stim_sequencer
  import wb_stim_pkg::*;
#(
  parameter int unsigned IQ_DEPTH  = 4,
  parameter int unsigned DQ_DEPTH  = 4,
  parameter int unsigned ACK_LAT   = 1,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
  parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inst_push,
  input  logic [WB_DW-1:0] i_inst_line,
  input  logic             i_data_push,
  input  logic [31:0]      i_data_word,
  output logic             o_iq_full,
  output logic             o_dq_full,
  output logic             o_ovf,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [31:0]      i_wb_adr,
  input  logic [WB_SW-1:0] i_wb_sel,
  input  logic [WB_DW-1:0] i_wb_wdat,
  output logic [WB_DW-1:0] o_wb_rdat,
  output logic             o_wb_ack,
  output logic             o_wb_err,
  output logic             o_st_valid,
  output logic [31:0]      o_st_adr,
  output logic [WB_DW-1:0] o_st_dat,
  output logic [WB_SW-1:0] o_st_sel
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             we_q;
  logic [31:0]      adr_q;
  logic [WB_SW-1:0] sel_q;
  logic [WB_DW-1:0] wdat_q;

  logic             accept, ack_d, err_d, st_valid_d;
  logic [WB_DW-1:0] rdat_d;
  logic             iq_pop, dq_pop, iq_empty, dq_empty, iq_ovf, dq_ovf;
  logic [WB_DW-1:0] iq_head;
  logic [31:0]      dq_head;
  logic [$clog2(IQ_DEPTH):0] iq_count;
  logic [$clog2(DQ_DEPTH):0] dq_count;

  // Occupancy is not needed by the sequencer itself.
  logic unused_counts;
  assign unused_counts = ^{iq_count, dq_count};

  stim_fifo #(.WIDTH(WB_DW), .DEPTH(IQ_DEPTH)) u_iq (
    .clk(i_clk), .rst_n(i_rst_n), .push(i_inst_push), .din(i_inst_line),
    .pop(iq_pop), .dout(iq_head), .full(o_iq_full), .empty(iq_empty),
    .count(iq_count), .ovf(iq_ovf)
  );

  stim_fifo #(.WIDTH(32), .DEPTH(DQ_DEPTH)) u_dq (
    .clk(i_clk), .rst_n(i_rst_n), .push(i_data_push), .din(i_data_word),
    .pop(dq_pop), .dout(dq_head), .full(o_dq_full), .empty(dq_empty),
    .count(dq_count), .ovf(dq_ovf)
  );

  // The response is decided on the last LAT cycle so the registered ack lands
  // in the cycle after edge N+ACK_LAT; RESP is the ack cycle itself, during
  // which no new request is accepted.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    wait_d     = wait_q;
    accept     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    st_valid_d = 1'b0;
    rdat_d     = '0;
    iq_pop     = 1'b0;
    dq_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          accept  = 1'b1;
          lat_d   = 4'(ACK_LAT - 1);
          state_d = LAT;
        end
      end
      LAT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (lat_q != '0) begin
          lat_d = lat_q - 4'd1;
        end else begin
          state_d = RESP;
          if (we_q) begin
            ack_d      = 1'b1;
            st_valid_d = 1'b1;
          end else if (adr_q < DATA_BASE) begin
            ack_d = 1'b1;
            if (!iq_empty) begin
              rdat_d = iq_head;
              iq_pop = 1'b1;
            end else begin
              rdat_d = {4{NOP_WORD}};
            end
          end else if (!dq_empty) begin
            ack_d  = 1'b1;
            rdat_d = {4{dq_head}};
            dq_pop = 1'b1;
          end else begin
            wait_d  = '0;
            state_d = WAITD;
          end
        end
      end
      WAITD: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (!dq_empty) begin
          ack_d   = 1'b1;
          rdat_d  = {4{dq_head}};
          dq_pop  = 1'b1;
          state_d = RESP;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      wait_q     <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      wdat_q     <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wb_rdat  <= '0;
      o_st_valid <= 1'b0;
      o_st_adr   <= '0;
      o_st_dat   <= '0;
      o_st_sel   <= '0;
      o_ovf      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      wait_q     <= wait_d;
      if (accept) begin
        we_q   <= i_wb_we;
        adr_q  <= i_wb_adr;
        sel_q  <= i_wb_sel;
        wdat_q <= i_wb_wdat;
      end
      o_wb_ack   <= ack_d;
      o_wb_err   <= err_d;
      o_wb_rdat  <= rdat_d;
      o_st_valid <= st_valid_d;
      if (st_valid_d) begin
        o_st_adr <= adr_q;
        o_st_dat <= wdat_q;
        o_st_sel <= sel_q;
      end
      o_ovf <= o_ovf | iq_ovf | dq_ovf;
    end
  end

endmodule

// File: tb/tb_wb_stim_sequencer.sv
// Directed self-checking bench for wb_stim_sequencer.
module tb_wb_stim_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inst_push = 1'b0;
  logic [127:0] inst_line = '0;
  logic         data_push = 1'b0;
  logic [31:0]  data_word = '0;
  logic         iq_full, dq_full, ovf;
  logic         wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0]  wb_adr = '0;
  logic [15:0]  wb_sel = '0;
  logic [127:0] wb_wdat = '0;
  logic [127:0] wb_rdat;
  logic         wb_ack, wb_err;
  logic         st_valid;
  logic [31:0]  st_adr;
  logic [127:0] st_dat;
  logic [15:0]  st_sel;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  logic         r_ack, r_err, r_stv, r_tail, seen;
  logic [127:0] r_dat;
  int unsigned  r_cyc;

  localparam logic [127:0] LINE0 = 128'hF0801003F0801003F0801003F0800003;
  localparam logic [127:0] NOPL  = 128'hF0801003F0801003F0801003F0801003;

  always #5 clk = ~clk;

  wb_stim_sequencer #(
    .IQ_DEPTH(4), .DQ_DEPTH(4), .ACK_LAT(1), .TIMEOUT(64),
    .DATA_BASE(32'h0000_1000), .NOP_WORD(32'hF0801003)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inst_push(inst_push), .i_inst_line(inst_line),
    .i_data_push(data_push), .i_data_word(data_word),
    .o_iq_full(iq_full), .o_dq_full(dq_full), .o_ovf(ovf),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_adr(wb_adr), .i_wb_sel(wb_sel), .i_wb_wdat(wb_wdat),
    .o_wb_rdat(wb_rdat), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_st_valid(st_valid), .o_st_adr(st_adr), .o_st_dat(st_dat), .o_st_sel(st_sel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [127:0] line);
    inst_push = 1'b1; inst_line = line;
    step();
    inst_push = 1'b0;
  endtask

  task automatic push_data(input logic [31:0] word);
    data_push = 1'b1; data_word = word;
    step();
    data_push = 1'b0;
  endtask

  // Drives one request until ack/err or the cycle limit, then drops it and
  // idles one cycle; tail reports any response activity in that idle cycle.
  task automatic bus_op(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                        input logic [127:0] wdat, input int unsigned limit,
                        output logic ack, output logic err, output logic [127:0] rdat,
                        output logic stv, output int unsigned cyc_n, output logic tail);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_wdat = wdat;
    ack = 1'b0; err = 1'b0; rdat = '0; stv = 1'b0; cyc_n = 0;
    while (cyc_n < limit && !ack && !err) begin
      step();
      cyc_n++;
      ack = wb_ack; err = wb_err; rdat = wb_rdat; stv = st_valid;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
    tail = wb_ack | wb_err | st_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests_run++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin tests_failed++; $display("FAIL rst_ackerr: got %b%b want 00", wb_ack, wb_err); end
    tests_run++; if (wb_rdat !== '0) begin tests_failed++; $display("FAIL rst_rdat: got %h want 0", wb_rdat); end
    tests_run++; if ({st_valid, iq_full, dq_full, ovf} !== 4'b0) begin tests_failed++; $display("FAIL rst_flags: got %b want 0000", {st_valid, iq_full, dq_full, ovf}); end
    tests_run++; if (st_adr !== '0 || st_sel !== '0 || st_dat !== '0) begin tests_failed++; $display("FAIL rst_st: got %h %h %h want 0", st_adr, st_sel, st_dat); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_inst_read();
    push_inst(LINE0);
    bus_op(1'b0, 32'h0000_0000, 16'hFFFF, '0, 10, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
    tests_run++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin tests_failed++; $display("FAIL ir_ack: got ack=%b err=%b want 1 0", r_ack, r_err); end
    tests_run++; if (r_cyc !== 2) begin tests_failed++; $display("FAIL ir_latency: got %0d want 2", r_cyc); end
    tests_run++; if (r_dat !== LINE0) begin tests_failed++; $display("FAIL ir_data: got %h want %h", r_dat, LINE0); end
    tests_run++; if (r_tail !== 1'b0) begin tests_failed++; $display("FAIL ir_pulse: got %b want 0", r_tail); end
    tests_run++; if (dut.u_iq.count !== 3'd0) begin tests_failed++; $display("FAIL ir_iqcount: got %0d want 0", dut.u_iq.count); end
  endtask

  task automatic test_empty_iq();
    bus_op(1'b0, 32'h0000_0010, 16'hFFFF, '0, 10, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
    tests_run++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin tests_failed++; $display("FAIL nop_ack: got ack=%b err=%b want 1 0", r_ack, r_err); end
    tests_run++; if (r_dat !== NOPL) begin tests_failed++; $display("FAIL nop_data: got %h want %h", r_dat, NOPL); end
    tests_run++; if (r_cyc !== 2) begin tests_failed++; $display("FAIL nop_latency: got %0d want 2", r_cyc); end
  endtask

  task automatic test_data_read();
    push_data(32'h0000_0005);
    tests_run++; if (dut.u_dq.count !== 3'd1) begin tests_failed++; $display("FAIL dr_pushcount: got %0d want 1", dut.u_dq.count); end
    bus_op(1'b0, 32'h0000_1000, 16'hFFFF, '0, 10, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
    tests_run++; if (r_ack !== 1'b1) begin tests_failed++; $display("FAIL dr_ack: got %b want 1", r_ack); end
    tests_run++; if (r_dat !== {4{32'h0000_0005}}) begin tests_failed++; $display("FAIL dr_data: got %h want %h", r_dat, {4{32'h0000_0005}}); end
    tests_run++; if (dut.u_dq.count !== 3'd0) begin tests_failed++; $display("FAIL dr_dqcount: got %0d want 0", dut.u_dq.count); end
    tests_run++; if (r_stv !== 1'b0) begin tests_failed++; $display("FAIL dr_nostore: got %b want 0", r_stv); end
  endtask

  task automatic test_store();
    logic [127:0] wd;
    wd = 128'h0000_0000_0000_0000_0000_0006_0000_0000;
    bus_op(1'b1, 32'h0000_1004, 16'h00F0, wd, 10, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
    tests_run++; if (r_ack !== 1'b1 || r_stv !== 1'b1) begin tests_failed++; $display("FAIL st_pulse: got ack=%b st=%b want 1 1", r_ack, r_stv); end
    tests_run++; if (r_cyc !== 2) begin tests_failed++; $display("FAIL st_latency: got %0d want 2", r_cyc); end
    tests_run++; if (st_adr !== 32'h0000_1004) begin tests_failed++; $display("FAIL st_adr: got %h want 00001004", st_adr); end
    tests_run++; if (st_sel !== 16'h00F0) begin tests_failed++; $display("FAIL st_sel: got %h want 00f0", st_sel); end
    tests_run++; if (st_dat !== wd) begin tests_failed++; $display("FAIL st_dat: got %h want %h", st_dat, wd); end
    tests_run++; if (r_tail !== 1'b0) begin tests_failed++; $display("FAIL st_single: got %b want 0", r_tail); end
  endtask

  task automatic test_timeout();
    bus_op(1'b0, 32'h0000_1000, 16'hFFFF, '0, 200, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
    tests_run++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin tests_failed++; $display("FAIL to_err: got err=%b ack=%b want 1 0", r_err, r_ack); end
    tests_run++; if (r_cyc !== 66) begin tests_failed++; $display("FAIL to_latency: got %0d want 66", r_cyc); end
    tests_run++; if (r_dat !== '0) begin tests_failed++; $display("FAIL to_rdat: got %h want 0", r_dat); end
    tests_run++; if (r_tail !== 1'b0) begin tests_failed++; $display("FAIL to_single: got %b want 0", r_tail); end
  endtask

  task automatic test_late_data();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_1000; seen = 1'b0;
    repeat (12) begin
      step();
      if (wb_ack || wb_err) seen = 1'b1;
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL ld_wait: got response=%b want 0", seen); end
    push_data(32'h0000_0001);
    tests_run++; if (wb_ack !== 1'b0) begin tests_failed++; $display("FAIL ld_early: got %b want 0", wb_ack); end
    step();
    tests_run++; if (wb_ack !== 1'b1 || wb_err !== 1'b0) begin tests_failed++; $display("FAIL ld_ack: got ack=%b err=%b want 1 0", wb_ack, wb_err); end
    tests_run++; if (wb_rdat !== {4{32'h0000_0001}}) begin tests_failed++; $display("FAIL ld_data: got %h want %h", wb_rdat, {4{32'h0000_0001}}); end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    step();
    tests_run++; if (wb_ack !== 1'b0 || wb_rdat !== '0) begin tests_failed++; $display("FAIL ld_single: got ack=%b rdat=%h want 0 0", wb_ack, wb_rdat); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) push_inst({4{32'hA000_0000 + 32'(i)}});
    tests_run++; if (iq_full !== 1'b1 || ovf !== 1'b0) begin tests_failed++; $display("FAIL pp_fill: got full=%b ovf=%b want 1 0", iq_full, ovf); end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0020;
    step();
    inst_push = 1'b1; inst_line = {4{32'hA000_0004}};
    step();
    inst_push = 1'b0;
    tests_run++; if (wb_ack !== 1'b1 || wb_rdat !== {4{32'hA000_0000}}) begin tests_failed++; $display("FAIL pp_read: got ack=%b rdat=%h want 1 %h", wb_ack, wb_rdat, {4{32'hA000_0000}}); end
    tests_run++; if (iq_full !== 1'b1 || ovf !== 1'b0) begin tests_failed++; $display("FAIL pp_flags: got full=%b ovf=%b want 1 0", iq_full, ovf); end
    tests_run++; if (dut.u_iq.count !== 3'd4) begin tests_failed++; $display("FAIL pp_count: got %0d want 4", dut.u_iq.count); end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    step();
  endtask

  task automatic test_overflow_abort();
    logic [127:0] expq [4];
    push_inst({4{32'hBBBB_BBBB}});
    tests_run++; if (ovf !== 1'b1 || iq_full !== 1'b1) begin tests_failed++; $display("FAIL ov_flag: got ovf=%b full=%b want 1 1", ovf, iq_full); end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0030;
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0; seen = 1'b0;
    repeat (4) begin
      step();
      if (wb_ack || wb_err) seen = 1'b1;
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL ab_noack: got response=%b want 0", seen); end
    tests_run++; if (dut.u_iq.count !== 3'd4) begin tests_failed++; $display("FAIL ab_count: got %0d want 4", dut.u_iq.count); end
    for (int k = 0; k < 4; k++) expq[k] = {4{32'hA000_0001 + 32'(k)}};
    for (int k = 0; k < 4; k++) begin
      bus_op(1'b0, 32'h0000_0000, 16'hFFFF, '0, 10, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
      tests_run++; if (r_ack !== 1'b1 || r_dat !== expq[k]) begin tests_failed++; $display("FAIL ov_drain%0d: got ack=%b rdat=%h want 1 %h", k, r_ack, r_dat, expq[k]); end
    end
    bus_op(1'b0, 32'h0000_0000, 16'hFFFF, '0, 10, r_ack, r_err, r_dat, r_stv, r_cyc, r_tail);
    tests_run++; if (r_ack !== 1'b1 || r_dat !== NOPL) begin tests_failed++; $display("FAIL ov_lost: got ack=%b rdat=%h want 1 %h", r_ack, r_dat, NOPL); end
  endtask

  task automatic test_reset_mid();
    push_data(32'h0000_0077);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_1000;
    step();
    rst_n = 1'b0;
    #1;
    tests_run++; if (wb_ack !== 1'b0 || wb_rdat !== '0) begin tests_failed++; $display("FAIL rm_noack: got ack=%b rdat=%h want 0 0", wb_ack, wb_rdat); end
    tests_run++; if (dut.u_dq.count !== 3'd0 || ovf !== 1'b0) begin tests_failed++; $display("FAIL rm_clear: got count=%0d ovf=%b want 0 0", dut.u_dq.count, ovf); end
    step();
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst_n = 1'b1;
    step();
    tests_run++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin tests_failed++; $display("FAIL rm_after: got ack=%b err=%b want 0 0", wb_ack, wb_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, limit 500000", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_inst_read();
    test_empty_iq();
    test_data_read();
    test_store();
    test_timeout();
    test_late_data();
    test_push_pop_full();
    test_overflow_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
